// File: rtl/vnlp_job_arbiter_if.sv
// Bundles the requester side and the VNLP side of the job arbiter.
//   master : arbiter view (drives gnt, rsp_*, vnlp_start/base/full_precis)
//   slave  : environment view (requesters plus the VNLP datapath)
// Ports carried:
//   req, req_addr, req_full_precis, rsp_ack     requester -> arbiter
//   gnt, rsp_valid, rsp_norm2, rsp_norm2_full,
//   rsp_len, rsp_timeout                        arbiter -> requester
//   vnlp_start, vnlp_base, vnlp_full_precis     arbiter -> VNLP
//   vnlp_done, vnlp_norm2, vnlp_norm2_full,
//   vnlp_len                                    VNLP -> arbiter
interface vnlp_job_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 9,
  parameter int WORD_W = 24,
  parameter int PRECIS = 39,
  parameter int LEN_W  = 8
);
  logic [NREQ-1:0]        req;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ-1:0]        req_full_precis;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        rsp_valid;
  logic [NREQ-1:0]        rsp_ack;
  logic [WORD_W-1:0]      rsp_norm2;
  logic [PRECIS-1:0]      rsp_norm2_full;
  logic [LEN_W-1:0]       rsp_len;
  logic                   rsp_timeout;
  logic                   vnlp_start;
  logic [ADDR_W-1:0]      vnlp_base;
  logic                   vnlp_full_precis;
  logic                   vnlp_done;
  logic [WORD_W-1:0]      vnlp_norm2;
  logic [PRECIS-1:0]      vnlp_norm2_full;
  logic [LEN_W-1:0]       vnlp_len;

  modport master (
    input  req, req_addr, req_full_precis, rsp_ack,
           vnlp_done, vnlp_norm2, vnlp_norm2_full, vnlp_len,
    output gnt, rsp_valid, rsp_norm2, rsp_norm2_full, rsp_len, rsp_timeout,
           vnlp_start, vnlp_base, vnlp_full_precis
  );

  modport slave (
    output req, req_addr, req_full_precis, rsp_ack,
           vnlp_done, vnlp_norm2, vnlp_norm2_full, vnlp_len,
    input  gnt, rsp_valid, rsp_norm2, rsp_norm2_full, rsp_len, rsp_timeout,
           vnlp_start, vnlp_base, vnlp_full_precis
  );
endinterface

// File: rtl/vnlp_job_arbiter.sv
// Round-robin arbiter sharing one VNLP vector-norm datapath among NREQ
// requesters. One job in flight at a time; results (or a watchdog abort)
// are returned to the winning requester over a valid/ack handshake.
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   bus        vnlp_job_arbiter_if.master (requester and VNLP signals)
//   the_state  current FSM state, for debug
// All outputs are registered: a decision taken in one state becomes visible
// on the following cycle (gnt in LAUNCH, vnlp_start in the first WAIT cycle,
// rsp_valid in RESP).
//
// state  | meaning
// IDLE   | pick a round-robin winner among pending requests
// LAUNCH | grant visible; issue start to the VNLP, arm the watchdog
// WAIT   | wait for a done rising edge or watchdog expiry
// RESP   | result pending for the owner until it acks
module vnlp_job_arbiter #(
  parameter int NREQ    = 4,
  parameter int ADDR_W  = 9,
  parameter int WORD_W  = 24,
  parameter int PRECIS  = 39,
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic                    clk,
  input  logic                    reset,
  vnlp_job_arbiter_if.master      bus,
  output logic [1:0]              the_state
);
  localparam int PTR_W = $clog2(NREQ);
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_LAUNCH = 2'b01,
    S_WAIT   = 2'b10,
    S_RESP   = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, owner_q, win_idx;
  logic [PTR_W:0]    scan_idx;
  logic              win_found;
  logic              done_q;
  logic [WD_W-1:0]   wd_cnt_q;
  logic [NREQ-1:0]   gnt_q, rsp_valid_q;
  logic              start_q;
  logic [ADDR_W-1:0] base_q;
  logic              full_precis_q;
  logic [WORD_W-1:0] norm2_q;
  logic [PRECIS-1:0] norm2_full_q;
  logic [LEN_W-1:0]  len_q;
  logic              timeout_q;
  logic              done_edge, wd_expired, ack_fire;
  logic              grant_fire, capture_fire, abort_fire;

  // First set request bit at or above ptr, wrapping modulo NREQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int i = 0; i < NREQ; i++) begin
      scan_idx = {1'b0, ptr_q} + (PTR_W+1)'(i);
      if (scan_idx >= (PTR_W+1)'(NREQ))
        scan_idx = scan_idx - (PTR_W+1)'(NREQ);
      if (!win_found && bus.req[scan_idx[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan_idx[PTR_W-1:0];
      end
    end
  end

  // A done level left high by a previous job is not an edge.
  assign done_edge  = bus.vnlp_done & ~done_q;
  assign wd_expired = (wd_cnt_q == '0);
  assign ack_fire   = bus.rsp_ack[owner_q];

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    grant_fire   = 1'b0;
    capture_fire = 1'b0;
    abort_fire   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          grant_fire = 1'b1;
          state_d    = S_LAUNCH;
        end
      end
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT: begin
        // Completion takes priority over a simultaneous watchdog expiry.
        if (done_edge) begin
          capture_fire = 1'b1;
          state_d      = S_RESP;
        end else if (wd_expired) begin
          abort_fire = 1'b1;
          state_d    = S_RESP;
        end
      end
      S_RESP: begin
        if (ack_fire) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q         <= '0;
      owner_q       <= '0;
      done_q        <= 1'b0;
      wd_cnt_q      <= '0;
      gnt_q         <= '0;
      rsp_valid_q   <= '0;
      start_q       <= 1'b0;
      base_q        <= '0;
      full_precis_q <= 1'b0;
      norm2_q       <= '0;
      norm2_full_q  <= '0;
      len_q         <= '0;
      timeout_q     <= 1'b0;
    end else begin
      done_q  <= bus.vnlp_done;
      gnt_q   <= '0;
      start_q <= 1'b0;

      if (grant_fire) begin
        owner_q       <= win_idx;
        base_q        <= bus.req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
        full_precis_q <= bus.req_full_precis[win_idx];
        gnt_q         <= NREQ'(1) << win_idx;
        ptr_q         <= (win_idx == PTR_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;
      end

      // Watchdog is a down-counter: loaded in LAUNCH, expires at zero, so
      // the abort lands TIMEOUT+1 cycles after the visible start pulse.
      if (state_q == S_LAUNCH) begin
        start_q  <= 1'b1;
        wd_cnt_q <= WD_W'(TIMEOUT);
      end else if (state_q == S_WAIT && !wd_expired) begin
        wd_cnt_q <= wd_cnt_q - 1'b1;
      end

      if (capture_fire) begin
        norm2_q      <= bus.vnlp_norm2;
        norm2_full_q <= bus.vnlp_norm2_full;
        len_q        <= bus.vnlp_len;
        timeout_q    <= 1'b0;
        rsp_valid_q  <= NREQ'(1) << owner_q;
      end else if (abort_fire) begin
        norm2_q      <= '0;
        norm2_full_q <= '0;
        len_q        <= '0;
        timeout_q    <= 1'b1;
        rsp_valid_q  <= NREQ'(1) << owner_q;
      end

      if (state_q == S_RESP && ack_fire)
        rsp_valid_q <= '0;
    end
  end

  // Start is masked by reset so a job aborted by reset never sees a start.
  assign bus.vnlp_start       = start_q & ~reset;
  assign bus.gnt              = gnt_q;
  assign bus.rsp_valid        = rsp_valid_q;
  assign bus.rsp_norm2        = norm2_q;
  assign bus.rsp_norm2_full   = norm2_full_q;
  assign bus.rsp_len          = len_q;
  assign bus.rsp_timeout      = timeout_q;
  assign bus.vnlp_base        = base_q;
  assign bus.vnlp_full_precis = full_precis_q;
  assign the_state            = state_q;
endmodule

// File: tb/tb_vnlp_job_arbiter.sv
module tb_vnlp_job_arbiter;
  localparam int NREQ    = 4;
  localparam int ADDR_W  = 9;
  localparam int WORD_W  = 24;
  localparam int PRECIS  = 39;
  localparam int LEN_W   = 8;
  localparam int TIMEOUT = 1023;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] the_state;
  int         n_checks = 0;
  int         n_bad    = 0;

  vnlp_job_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .WORD_W(WORD_W),
                        .PRECIS(PRECIS), .LEN_W(LEN_W)) bus ();

  vnlp_job_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .WORD_W(WORD_W),
                     .PRECIS(PRECIS), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .the_state (the_state)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_addr(input int k, input logic [ADDR_W-1:0] a);
    bus.req_addr[k*ADDR_W +: ADDR_W] = a;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req = '0; bus.req_addr = '0; bus.req_full_precis = '0; bus.rsp_ack = '0;
    bus.vnlp_done = 1'b0; bus.vnlp_norm2 = '0; bus.vnlp_norm2_full = '0; bus.vnlp_len = '0;
    tick(2);
    n_checks++;
    if (the_state !== 2'b00) begin n_bad++; $display("FAIL reset_state got=%b exp=00", the_state); end
    n_checks++;
    if ({bus.gnt, bus.rsp_valid, bus.vnlp_start, bus.vnlp_base, bus.vnlp_full_precis} !== '0) begin
      n_bad++; $display("FAIL reset_ctrl gnt=%b rsp_valid=%b start=%b base=%h", bus.gnt, bus.rsp_valid, bus.vnlp_start, bus.vnlp_base);
    end
    n_checks++;
    if ({bus.rsp_norm2, bus.rsp_norm2_full, bus.rsp_len, bus.rsp_timeout} !== '0) begin
      n_bad++; $display("FAIL reset_data norm2=%h full=%h len=%h to=%b", bus.rsp_norm2, bus.rsp_norm2_full, bus.rsp_len, bus.rsp_timeout);
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    bus.req = 4'b0001; set_addr(0, 9'h000);
    tick();
    n_checks++;
    if (bus.gnt !== 4'b0001 || bus.vnlp_start !== 1'b0) begin
      n_bad++; $display("FAIL single_gnt gnt=%b start=%b exp gnt=0001 start=0", bus.gnt, bus.vnlp_start);
    end
    bus.req = '0;
    tick();
    n_checks++;
    if (bus.vnlp_start !== 1'b1 || bus.gnt !== 4'b0000 || bus.vnlp_base !== 9'h000 || the_state !== 2'b10) begin
      n_bad++; $display("FAIL single_start start=%b gnt=%b base=%h state=%b exp 1 0000 000 10", bus.vnlp_start, bus.gnt, bus.vnlp_base, the_state);
    end
    tick();
    n_checks++;
    if (bus.vnlp_start !== 1'b0) begin n_bad++; $display("FAIL single_start_pulse got=%b exp=0", bus.vnlp_start); end
    tick(18);
    bus.vnlp_done = 1'b1; bus.vnlp_norm2 = 24'h01_2345; bus.vnlp_norm2_full = 39'h12_3456_789A; bus.vnlp_len = 8'd2;
    n_checks++;
    if (bus.rsp_valid !== 4'b0000) begin n_bad++; $display("FAIL single_early_valid got=%b exp=0000", bus.rsp_valid); end
    tick();
    bus.vnlp_done = 1'b0;
    n_checks++;
    if (bus.rsp_valid !== 4'b0001 || bus.rsp_norm2 !== 24'h01_2345 || bus.rsp_len !== 8'd2 ||
        bus.rsp_norm2_full !== 39'h12_3456_789A || bus.rsp_timeout !== 1'b0) begin
      n_bad++; $display("FAIL single_rsp valid=%b norm2=%h full=%h len=%h to=%b exp 0001 012345 123456789a 02 0",
                        bus.rsp_valid, bus.rsp_norm2, bus.rsp_norm2_full, bus.rsp_len, bus.rsp_timeout);
    end
    bus.rsp_ack = 4'b0001;
    tick();
    bus.rsp_ack = '0;
    n_checks++;
    if (bus.rsp_valid !== 4'b0000 || the_state !== 2'b00) begin
      n_bad++; $display("FAIL single_ack valid=%b state=%b exp 0000 00", bus.rsp_valid, the_state);
    end
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] exp_oh;
    reset = 1'b1; tick(); reset = 1'b0;
    bus.req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      exp_oh = 4'b0001 << (j % 4);
      tick();
      n_checks++;
      if (bus.gnt !== exp_oh || bus.vnlp_start !== 1'b0) begin
        n_bad++; $display("FAIL rr_gnt job=%0d gnt=%b start=%b exp gnt=%b start=0", j, bus.gnt, bus.vnlp_start, exp_oh);
      end
      tick();
      bus.vnlp_done = 1'b1; bus.vnlp_norm2 = 24'(j + 16);
      tick();
      bus.vnlp_done = 1'b0;
      n_checks++;
      if (bus.rsp_valid !== exp_oh || bus.rsp_norm2 !== 24'(j + 16)) begin
        n_bad++; $display("FAIL rr_rsp job=%0d valid=%b norm2=%h exp %b %h", j, bus.rsp_valid, bus.rsp_norm2, exp_oh, 24'(j + 16));
      end
      bus.rsp_ack = exp_oh;
      tick();
      bus.rsp_ack = '0;
    end
    bus.req = '0;
  endtask

  task automatic test_stale_done();
    // pointer is 1 after the round-robin sequence
    bus.vnlp_done = 1'b1;
    bus.req = 4'b0010;
    tick();
    bus.req = '0;
    tick(4);
    n_checks++;
    if (the_state !== 2'b10 || bus.rsp_valid !== 4'b0000) begin
      n_bad++; $display("FAIL stale_level state=%b valid=%b exp 10 0000", the_state, bus.rsp_valid);
    end
    bus.vnlp_done = 1'b0;
    tick(5);
    n_checks++;
    if (the_state !== 2'b10) begin n_bad++; $display("FAIL stale_wait state=%b exp=10", the_state); end
    bus.vnlp_done = 1'b1; bus.vnlp_norm2 = 24'h0A_BCDE; bus.vnlp_norm2_full = 39'h7F_0000_0001; bus.vnlp_len = 8'd7;
    tick();
    n_checks++;
    if (bus.rsp_valid !== 4'b0010 || bus.rsp_norm2 !== 24'h0A_BCDE || bus.rsp_norm2_full !== 39'h7F_0000_0001 || bus.rsp_len !== 8'd7) begin
      n_bad++; $display("FAIL stale_capture valid=%b norm2=%h full=%h len=%h exp 0010 0abcde 7f00000001 07",
                        bus.rsp_valid, bus.rsp_norm2, bus.rsp_norm2_full, bus.rsp_len);
    end
    bus.rsp_ack = 4'b0010;
    tick();
    bus.rsp_ack = '0; bus.vnlp_done = 1'b0;
  endtask

  task automatic test_timeout();
    // pointer is 2
    bus.req = 4'b0100; set_addr(2, 9'h1A5); bus.req_full_precis = 4'b0100;
    tick();
    bus.req = '0; bus.req_full_precis = '0;
    n_checks++;
    if (bus.gnt !== 4'b0100 || bus.vnlp_base !== 9'h1A5 || bus.vnlp_full_precis !== 1'b1) begin
      n_bad++; $display("FAIL to_launch gnt=%b base=%h fp=%b exp 0100 1a5 1", bus.gnt, bus.vnlp_base, bus.vnlp_full_precis);
    end
    bus.vnlp_norm2 = 24'hFF_FFFF; bus.vnlp_norm2_full = '1; bus.vnlp_len = 8'hFF;
    tick();
    n_checks++;
    if (bus.vnlp_start !== 1'b1) begin n_bad++; $display("FAIL to_start got=%b exp=1", bus.vnlp_start); end
    tick(TIMEOUT);
    n_checks++;
    if (bus.rsp_valid !== 4'b0000 || the_state !== 2'b10 || bus.vnlp_base !== 9'h1A5) begin
      n_bad++; $display("FAIL to_early valid=%b state=%b base=%h exp 0000 10 1a5", bus.rsp_valid, the_state, bus.vnlp_base);
    end
    tick();
    n_checks++;
    if (bus.rsp_valid !== 4'b0100 || bus.rsp_timeout !== 1'b1 ||
        {bus.rsp_norm2, bus.rsp_norm2_full, bus.rsp_len} !== '0) begin
      n_bad++; $display("FAIL to_rsp valid=%b to=%b norm2=%h full=%h len=%h exp 0100 1 0 0 0",
                        bus.rsp_valid, bus.rsp_timeout, bus.rsp_norm2, bus.rsp_norm2_full, bus.rsp_len);
    end
    bus.rsp_ack = 4'b0100;
    tick();
    bus.rsp_ack = '0;
    // next job normal; pointer must be 3
    bus.req = 4'b1111;
    tick();
    bus.req = '0;
    n_checks++;
    if (bus.gnt !== 4'b1000) begin n_bad++; $display("FAIL to_next_gnt got=%b exp=1000", bus.gnt); end
    tick();
    bus.vnlp_done = 1'b1; bus.vnlp_norm2 = 24'h3C_0001; bus.vnlp_len = 8'd9;
    tick();
    bus.vnlp_done = 1'b0;
    n_checks++;
    if (bus.rsp_valid !== 4'b1000 || bus.rsp_timeout !== 1'b0 || bus.rsp_norm2 !== 24'h3C_0001 || bus.rsp_len !== 8'd9) begin
      n_bad++; $display("FAIL to_next_rsp valid=%b to=%b norm2=%h len=%h exp 1000 0 3c0001 09",
                        bus.rsp_valid, bus.rsp_timeout, bus.rsp_norm2, bus.rsp_len);
    end
    bus.rsp_ack = 4'b1000;
    tick();
    bus.rsp_ack = '0;
  endtask

  task automatic test_ack_discipline();
    // pointer is 0
    bus.req = 4'b0100;
    tick();
    bus.req = '0;
    tick();
    bus.vnlp_done = 1'b1;
    tick();
    bus.vnlp_done = 1'b0;
    bus.req = 4'b1000;
    bus.rsp_ack = 4'b0010;
    tick(2);
    n_checks++;
    if (the_state !== 2'b11 || bus.rsp_valid !== 4'b0100 || bus.gnt !== 4'b0000) begin
      n_bad++; $display("FAIL ack_wrong_port state=%b valid=%b gnt=%b exp 11 0100 0000", the_state, bus.rsp_valid, bus.gnt);
    end
    bus.rsp_ack = 4'b0100;
    tick();
    bus.rsp_ack = '0;
    n_checks++;
    if (the_state !== 2'b00 || bus.rsp_valid !== 4'b0000 || bus.gnt !== 4'b0000) begin
      n_bad++; $display("FAIL ack_right_port state=%b valid=%b gnt=%b exp 00 0000 0000", the_state, bus.rsp_valid, bus.gnt);
    end
    tick();
    bus.req = '0;
    n_checks++;
    if (bus.gnt !== 4'b1000) begin n_bad++; $display("FAIL ack_next_gnt got=%b exp=1000", bus.gnt); end
    tick();
    bus.vnlp_done = 1'b1;
    tick();
    bus.vnlp_done = 1'b0;
    bus.rsp_ack = 4'b1000;
    tick();
    bus.rsp_ack = '0;
  endtask

  task automatic test_reset_in_wait();
    // pointer is 0; granting requester 1 moves it to 2
    bus.req = 4'b0010;
    tick();
    bus.req = '0;
    tick();
    tick(5);
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus.vnlp_start !== 1'b0) begin n_bad++; $display("FAIL rst_start_mask got=%b exp=0", bus.vnlp_start); end
    tick();
    reset = 1'b0;
    n_checks++;
    if (the_state !== 2'b00 || {bus.gnt, bus.rsp_valid, bus.vnlp_start, bus.vnlp_base} !== '0) begin
      n_bad++; $display("FAIL rst_outputs state=%b gnt=%b valid=%b start=%b base=%h exp all 0",
                        the_state, bus.gnt, bus.rsp_valid, bus.vnlp_start, bus.vnlp_base);
    end
    bus.vnlp_done = 1'b1;
    tick();
    bus.vnlp_done = 1'b0;
    tick(2);
    n_checks++;
    if (the_state !== 2'b00 || bus.rsp_valid !== 4'b0000) begin
      n_bad++; $display("FAIL rst_done_ignored state=%b valid=%b exp 00 0000", the_state, bus.rsp_valid);
    end
    bus.req = 4'b1111;
    tick();
    bus.req = '0;
    n_checks++;
    if (bus.gnt !== 4'b0001) begin n_bad++; $display("FAIL rst_ptr_gnt got=%b exp=0001", bus.gnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stale_done();
    test_timeout();
    test_ack_discipline();
    test_reset_in_wait();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule
